// File: rtl/int_adder_mc_if.sv
// Operand/result handshake bundle for the multi-cycle wide adder.
// slave is the adder side, master is the issuing/consuming side.
interface int_adder_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHUNKS = 4
);
    localparam int W = DATA_WIDTH * NUM_CHUNKS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport slave (
        input  in_valid, op_a, op_b, carry_in, op_sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport master (
        output in_valid, op_a, op_b, carry_in, op_sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );
endinterface

// File: rtl/int_adder_mc.sv
// Wide add/subtract computed one DATA_WIDTH chunk per cycle, LSB chunk first,
// with the inter-chunk carry held in a register.
module int_adder_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHUNKS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    int_adder_mc_if.slave   bus
);
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                 state_q;
    logic [IW-1:0]                          idx_q;
    logic [NUM_CHUNKS-1:0][DATA_WIDTH-1:0]  a_q, b_q, res_q;
    logic                                   carry_q, cout_q, ovf_q;
    logic                                   in_ready_q, out_valid_q, busy_q;

    logic [DATA_WIDTH-1:0]                  a_cur, b_cur;
    logic [DATA_WIDTH:0]                    sum_d;
    logic                                   ovf_d;

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx_q == IW'(k)) begin
                a_cur = a_q[k];
                b_cur = b_q[k];
            end
        end
        sum_d = {1'b0, a_cur} + {1'b0, b_cur} + {{DATA_WIDTH{1'b0}}, carry_q};
        // Carry into the MSB is recovered from the MSB sum bit and operand bits.
        ovf_d = (a_cur[DATA_WIDTH-1] ^ b_cur[DATA_WIDTH-1] ^ sum_d[DATA_WIDTH-1])
                ^ sum_d[DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q    <= bus.op_sub | bus.carry_in;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NUM_CHUNKS; k++)
                        if (idx_q == IW'(k)) res_q[k] <= sum_d[DATA_WIDTH-1:0];
                    carry_q <= sum_d[DATA_WIDTH];
                    if (idx_q == LAST) begin
                        cout_q      <= sum_d[DATA_WIDTH];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_int_adder_mc.sv
// Randomized and directed checks of int_adder_mc against a plain-arithmetic model.
module tb_int_adder_mc;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int W  = DW * NC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    int_adder_mc_if #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) bus ();
    int_adder_mc #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // {overflow, carry_out, result} from whole-word arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic ci, sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [W-1:0] a, b, input logic ci, sub);
        int n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
        bus.op_a = a; bus.op_b = b; bus.carry_in = ci; bus.op_sub = sub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op_a = rnd(); bus.op_b = rnd();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] a, b, input logic ci, sub);
        logic [W+1:0] m;
        m = model(a, b, ci, sub);
        chk({tag, "_res"}, bus.result, m[W-1:0]);
        chk({tag, "_cout"}, W'(bus.carry_out), W'(m[W]));
        chk({tag, "_ovf"}, W'(bus.overflow), W'(m[W+1]));
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, b, input logic ci, sub,
                         input int hold);
        int lat;
        issue(a, b, ci, sub);
        chk({tag, "_busy_run"}, W'(bus.busy), 1);
        chk({tag, "_rdy_run"}, W'(bus.in_ready), 0);
        wait_done(lat);
        chk({tag, "_lat"}, W'(lat), NC);
        check_out(tag, a, b, ci, sub);
        repeat (hold) begin @(posedge clk); #1; end
        release_out();
        chk({tag, "_idle_rdy"}, W'(bus.in_ready), 1);
        chk({tag, "_idle_ov"}, W'(bus.out_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, a2, b2, ones, msb, held;
        int lat;
        ones = '1;
        msb  = {1'b1, {(W-1){1'b0}}};
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.carry_in = 1'b0; bus.op_sub = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(bus.in_ready), 1);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_busy", W'(bus.busy), 0);
        chk("rst_result", bus.result, 0);
        chk("rst_cout", W'(bus.carry_out), 0);
        chk("rst_ovf", W'(bus.overflow), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("xcarry", {32'h0, {96{1'b1}}}, 1, 1'b0, 1'b0, 0);
        do_op("wrap", ones, 0, 1'b1, 1'b0, 0);
        do_op("sovf", ~msb, 1, 1'b0, 1'b0, 1);
        do_op("sub57", 5, 7, 1'b1, 1'b1, 0);
        do_op("subovf", msb, 1, 1'b0, 1'b1, 2);

        issue({32'h0, {96{1'b1}}}, 1, 1'b0, 1'b0);
        wait_done(lat);
        chk("xcarry_const", bus.result, {32'h1, 96'h0});
        release_out();
        issue(~msb, 1, 1'b0, 1'b0);
        wait_done(lat);
        chk("sovf_const_res", bus.result, msb);
        chk("sovf_const_ovf", W'(bus.overflow), 1);
        release_out();
        issue(5, 7, 1'b1, 1'b1);
        wait_done(lat);
        chk("sub57_const", bus.result, ones - 1);
        chk("sub57_cout", W'(bus.carry_out), 0);
        release_out();

        // Backpressure with a pending request held on the input.
        a = rnd(); b = rnd(); a2 = rnd(); b2 = rnd();
        issue(a, b, 1'b1, 1'b0);
        wait_done(lat);
        check_out("bp1", a, b, 1'b1, 1'b0);
        held = bus.result;
        bus.op_a = a2; bus.op_b = b2; bus.carry_in = 1'b0; bus.op_sub = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_ov_hold", W'(bus.out_valid), 1);
            chk("bp_res_hold", bus.result, held);
            chk("bp_rdy_low", W'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_idle_rdy", W'(bus.in_ready), 1);
        chk("bp_idle_busy", W'(bus.busy), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_accept", W'(bus.busy), 1);
        wait_done(lat);
        chk("bp2_lat", W'(lat), NC);
        check_out("bp2", a2, b2, 1'b0, 1'b1);
        release_out();

        // Reset while chunk 2 is being computed.
        issue({32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 32'h8765_4321}, ones, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy", W'(bus.in_ready), 1);
        chk("mrst_ov", W'(bus.out_valid), 0);
        chk("mrst_busy", W'(bus.busy), 0);
        chk("mrst_res", bus.result, 0);
        chk("mrst_cout", W'(bus.carry_out), 0);
        chk("mrst_ovf", W'(bus.overflow), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_no_out", W'(bus.out_valid), 0);
        do_op("after_rst", 1, 2, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            logic ci, sub;
            a = rnd(); b = rnd();
            if (i % 7 == 0) a = ones;
            if (i % 5 == 0) b = msb;
            ci = 1'($urandom); sub = 1'($urandom);
            do_op("rnd", a, b, ci, sub, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
